// File: rtl/mul_fu.sv
// RISC-V M-extension multiply unit: operand sign handling around the unsigned actual_mult,
// with a credit-throttled in-order result FIFO. Define MUL_PERF_CNT_EN to add perf_ops/perf_stall.

module actual_mult (
    input  logic        clk,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] prod
);
    localparam int LEVELS = 8;  // 3:2 reduction depth taking 32 rows down to 2

    genvar gi;

    logic [63:0] pp [32];
    logic [63:0] cs_sum_d;
    logic [63:0] cs_carry_d;
    logic [63:0] cs_sum_q;
    logic [63:0] cs_carry_q;

    generate
        for (gi = 0; gi < 32; gi++) begin : g_pp
            assign pp[gi] = b[gi] ? ({32'd0, a} << gi) : 64'd0;
        end
    endgenerate

    always_comb begin
        logic [63:0] rows [32];
        logic [63:0] nxt  [32];
        int          n;
        int          groups;
        int          rem;
        rows   = pp;
        nxt    = '{default: '0};
        n      = 32;
        groups = 0;
        rem    = 0;
        for (int lv = 0; lv < LEVELS; lv++) begin
            nxt    = '{default: '0};
            groups = n / 3;
            rem    = n % 3;
            for (int g = 0; g < 10; g++) begin
                if (g < groups) begin
                    nxt[2*g]   = rows[3*g] ^ rows[3*g+1] ^ rows[3*g+2];
                    nxt[2*g+1] = ((rows[3*g] & rows[3*g+1]) |
                                  (rows[3*g] & rows[3*g+2]) |
                                  (rows[3*g+1] & rows[3*g+2])) << 1;
                end
            end
            for (int r = 0; r < 2; r++) begin
                if (r < rem) begin
                    nxt[2*groups+r] = rows[3*groups+r];
                end
            end
            rows = nxt;
            n    = 2 * groups + rem;
        end
        cs_sum_d   = rows[0];
        cs_carry_d = rows[1];
    end

    // Pipeline register in carry-save form; no enable, so it captures every cycle.
    always_ff @(posedge clk) begin
        cs_sum_q   <= cs_sum_d;
        cs_carry_q <= cs_carry_d;
    end

    assign prod = cs_sum_q + cs_carry_q;

endmodule

module mul_fu #(
    parameter int TAG_W     = 6,
    parameter int OUT_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [31:0]      in_rs1,
    input  logic [31:0]      in_rs2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [TAG_W-1:0] out_tag
`ifdef MUL_PERF_CNT_EN
    ,
    output logic [31:0]      perf_ops,
    output logic [31:0]      perf_stall
`endif
);
    localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int CNT_W = $clog2(OUT_DEPTH + 1);
    localparam int OCC_W = CNT_W + 2;
    localparam logic [OCC_W-1:0] OCC_LIMIT = OCC_W'(OUT_DEPTH);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(OUT_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(OUT_DEPTH - 1);

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    logic             accept;
    logic             sign_a;
    logic             sign_b;
    logic [OCC_W-1:0] occupancy;

    logic             s1_v_q,     s1_v_d;
    logic             s1_neg_q,   s1_neg_d;
    logic [1:0]       s1_op_q,    s1_op_d;
    logic [TAG_W-1:0] s1_tag_q,   s1_tag_d;
    logic [31:0]      s1_mag_a_q, s1_mag_a_d;
    logic [31:0]      s1_mag_b_q, s1_mag_b_d;

    logic             s2_v_q,   s2_v_d;
    logic             s2_neg_q, s2_neg_d;
    logic [1:0]       s2_op_q,  s2_op_d;
    logic [TAG_W-1:0] s2_tag_q, s2_tag_d;

    logic [63:0]      mult_prod;
    logic [63:0]      signed_prod;
    logic [31:0]      wb_result;

    logic [31:0]      fifo_res_q [OUT_DEPTH];
    logic [31:0]      fifo_res_d [OUT_DEPTH];
    logic [TAG_W-1:0] fifo_tag_q [OUT_DEPTH];
    logic [TAG_W-1:0] fifo_tag_d [OUT_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             push;
    logic             pop;

    // Credit counts everything already committed to a FIFO slot; a pop frees it only next cycle.
    always_comb begin
        occupancy = OCC_W'(count_q) + OCC_W'(s1_v_q) + OCC_W'(s2_v_q);
        in_ready  = !flush && (occupancy < OCC_LIMIT);
        accept    = in_valid && in_ready;
    end

    always_comb begin
        sign_a     = ((in_op == 2'b01) || (in_op == 2'b10)) && in_rs1[31];
        sign_b     = (in_op == 2'b01) && in_rs2[31];
        s1_mag_a_d = sign_a ? (~in_rs1 + 32'd1) : in_rs1;
        s1_mag_b_d = sign_b ? (~in_rs2 + 32'd1) : in_rs2;
        s1_neg_d   = sign_a ^ sign_b;
        s1_op_d    = in_op;
        s1_tag_d   = in_tag;
        s1_v_d     = accept;
    end

    always_comb begin
        s2_neg_d = s1_neg_q;
        s2_op_d  = s1_op_q;
        s2_tag_d = s1_tag_q;
        s2_v_d   = s1_v_q && !flush;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q     <= 1'b0;
            s1_neg_q   <= 1'b0;
            s1_op_q    <= 2'b00;
            s1_tag_q   <= '0;
            s1_mag_a_q <= '0;
            s1_mag_b_q <= '0;
            s2_v_q     <= 1'b0;
            s2_neg_q   <= 1'b0;
            s2_op_q    <= 2'b00;
            s2_tag_q   <= '0;
        end else begin
            s1_v_q     <= s1_v_d;
            s1_neg_q   <= s1_neg_d;
            s1_op_q    <= s1_op_d;
            s1_tag_q   <= s1_tag_d;
            s1_mag_a_q <= s1_mag_a_d;
            s1_mag_b_q <= s1_mag_b_d;
            s2_v_q     <= s2_v_d;
            s2_neg_q   <= s2_neg_d;
            s2_op_q    <= s2_op_d;
            s2_tag_q   <= s2_tag_d;
        end
    end

    actual_mult u_mult (
        .clk  (clk),
        .a    (s1_mag_a_q),
        .b    (s1_mag_b_q),
        .prod (mult_prod)
    );

    always_comb begin
        signed_prod = s2_neg_q ? (~mult_prod + 64'd1) : mult_prod;
        wb_result   = (s2_op_q == 2'b00) ? signed_prod[31:0] : signed_prod[63:32];
    end

    // Flush wins over push and pop; stored data is left behind but becomes unreachable.
    always_comb begin
        push       = s2_v_q && !flush;
        pop        = (count_q != '0) && out_ready && !flush;
        fifo_res_d = fifo_res_q;
        fifo_tag_d = fifo_tag_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                fifo_res_d[wr_ptr_q] = wb_result;
                fifo_tag_d[wr_ptr_q] = s2_tag_q;
                wr_ptr_d             = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_res_q <= '{default: '0};
            fifo_tag_q <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fifo_res_q <= fifo_res_d;
            fifo_tag_q <= fifo_tag_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    assign out_valid  = (count_q != '0);
    assign out_result = fifo_res_q[rd_ptr_q];
    assign out_tag    = fifo_tag_q[rd_ptr_q];

    fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && (count_q == CNT_FULL)));

`ifdef MUL_PERF_CNT_EN
    logic [31:0] perf_ops_q,   perf_ops_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_ops_d   = perf_ops_q + {31'd0, accept};
        perf_stall_d = perf_stall_q + {31'd0, (in_valid && !in_ready)};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_ops_q   <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_ops_q   <= perf_ops_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_ops   = perf_ops_q;
    assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_mul_fu.sv
// Bench for mul_fu: directed vector table, latency/backpressure/flush/reset sequences,
// and a randomized run scored against an arithmetic reference model.

module tb_mul_fu;
    localparam int TAG_W     = 6;
    localparam int OUT_DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [1:0]       in_op = 2'b00;
    logic [31:0]      in_rs1 = '0;
    logic [31:0]      in_rs2 = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [31:0]      out_result;
    logic [TAG_W-1:0] out_tag;
`ifdef MUL_PERF_CNT_EN
    logic [31:0]      perf_ops;
    logic [31:0]      perf_stall;
`endif

    mul_fu #(.TAG_W(TAG_W), .OUT_DEPTH(OUT_DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag)
`ifdef MUL_PERF_CNT_EN
        ,
        .perf_ops   (perf_ops),
        .perf_stall (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int accepts = 0;
    int stalls = 0;

    typedef struct {
        logic [31:0]      res;
        logic [TAG_W-1:0] tag;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [1:0]       op;
        logic [31:0]      a;
        logic [31:0]      b;
        logic [TAG_W-1:0] tag;
        logic [31:0]      exp;
    } vec_t;
    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: full-precision signed/unsigned product, then pick the half.
    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        logic signed [65:0] x;
        logic signed [65:0] y;
        logic signed [65:0] p;
        x = (op == 2'b01 || op == 2'b10) ? {{34{a[31]}}, a} : {34'd0, a};
        y = (op == 2'b01) ? {{34{b[31]}}, b} : {34'd0, b};
        p = x * y;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h0000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One isolated op: accepted this cycle (k), absent at k+2, at the FIFO head at k+3.
    task automatic issue_and_check(input string name, input logic [1:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic [TAG_W-1:0] tag,
                                   input logic [31:0] exp);
        in_valid = 1'b1;
        in_op    = op;
        in_rs1   = a;
        in_rs2   = b;
        in_tag   = tag;
        #1;
        check({name, "_ready"}, 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        step();
        check({name, "_early_valid"}, 32'(out_valid), 32'd0);
        step();
        check({name, "_valid"}, 32'(out_valid), 32'd1);
        check({name, "_result"}, out_result, exp);
        check({name, "_tag"}, 32'(out_tag), 32'(tag));
        step();
    endtask

    // Scoreboard monitor: every accepted op must come back in order with the model result.
    initial begin
        exp_t h;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sb.delete();
                accepts = 0;
                stalls  = 0;
            end else begin
                check("credit_ready", 32'(in_ready),
                      32'(!flush && (sb.size() < OUT_DEPTH)));
                if (in_valid && !in_ready) stalls++;
                if (flush) begin
                    sb.delete();
                end else begin
                    if (out_valid && out_ready) begin
                        if (sb.size() == 0) begin
                            check("spurious_out_valid", 32'(out_valid), 32'd0);
                        end else begin
                            h = sb.pop_front();
                            check("sb_result", out_result, h.res);
                            check("sb_tag", 32'(out_tag), 32'(h.tag));
                            $display("pop tag=%0d result=0x%08h", out_tag, out_result);
                        end
                    end
                    if (in_valid && in_ready) begin
                        sb.push_back('{res: ref_result(in_op, in_rs1, in_rs2), tag: in_tag});
                        accepts++;
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        bit drained;

        vecs[0]  = '{op: 2'b00, a: 32'd7,          b: 32'd6,          tag: 6'd5,  exp: 32'h0000_002A};
        vecs[1]  = '{op: 2'b01, a: 32'hFFFF_FFFF, b: 32'h0000_0002, tag: 6'd1,  exp: 32'hFFFF_FFFF};
        vecs[2]  = '{op: 2'b10, a: 32'hFFFF_FFFF, b: 32'h0000_0002, tag: 6'd2,  exp: 32'hFFFF_FFFF};
        vecs[3]  = '{op: 2'b11, a: 32'hFFFF_FFFF, b: 32'h0000_0002, tag: 6'd3,  exp: 32'h0000_0001};
        vecs[4]  = '{op: 2'b01, a: 32'h8000_0000, b: 32'h8000_0000, tag: 6'd4,  exp: 32'h4000_0000};
        vecs[5]  = '{op: 2'b00, a: 32'h8000_0000, b: 32'h8000_0000, tag: 6'd6,  exp: 32'h0000_0000};
        vecs[6]  = '{op: 2'b11, a: 32'h8000_0000, b: 32'h8000_0000, tag: 6'd7,  exp: 32'h4000_0000};
        vecs[7]  = '{op: 2'b10, a: 32'h8000_0000, b: 32'h8000_0000, tag: 6'd8,  exp: 32'hC000_0000};
        vecs[8]  = '{op: 2'b00, a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, tag: 6'd9,  exp: 32'h0000_0001};
        vecs[9]  = '{op: 2'b01, a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, tag: 6'd10, exp: 32'h0000_0000};
        vecs[10] = '{op: 2'b01, a: 32'h7FFF_FFFF, b: 32'h8000_0000, tag: 6'd11, exp: 32'hC000_0000};
        vecs[11] = '{op: 2'b10, a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, tag: 6'd63, exp: 32'hFFFF_FFFF};

        step();
        step();
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_result", out_result, 32'd0);
        check("reset_out_tag", 32'(out_tag), 32'd0);
        rst_n = 1'b1;
        #1;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;

        for (int i = 0; i < 12; i++) begin
            issue_and_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                            vecs[i].tag, vecs[i].exp);
        end

        // Back-to-back MULH/MULHSU/MULHU: results in cycles 3, 4, 5.
        in_valid = 1'b1; in_rs1 = 32'hFFFF_FFFF; in_rs2 = 32'h0000_0002;
        in_op = 2'b01; in_tag = 6'd12;
        step();
        in_op = 2'b10; in_tag = 6'd13;
        step();
        in_op = 2'b11; in_tag = 6'd14;
        step();
        in_valid = 1'b0;
        check("b2b_c3_valid", 32'(out_valid), 32'd1);
        check("b2b_c3_result", out_result, 32'hFFFF_FFFF);
        check("b2b_c3_tag", 32'(out_tag), 32'd12);
        step();
        check("b2b_c4_valid", 32'(out_valid), 32'd1);
        check("b2b_c4_result", out_result, 32'hFFFF_FFFF);
        check("b2b_c4_tag", 32'(out_tag), 32'd13);
        step();
        check("b2b_c5_valid", 32'(out_valid), 32'd1);
        check("b2b_c5_result", out_result, 32'h0000_0001);
        check("b2b_c5_tag", 32'(out_tag), 32'd14);
        step();
        check("b2b_c6_valid", 32'(out_valid), 32'd0);

        // Backpressure: only OUT_DEPTH ops may be outstanding.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_op     = 2'b00;
        acc       = 0;
        for (int c = 0; c < 10; c++) begin
            in_tag = TAG_W'(acc);
            in_rs1 = 32'(acc + 1);
            in_rs2 = 32'd2;
            #1;
            if (in_ready) acc++;
            step();
        end
        check("bp_accepted", 32'(acc), 32'd4);
        #1;
        check("bp_ready_low", 32'(in_ready), 32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int d = 0; d < 4; d++) begin
            check($sformatf("bp_drain%0d_valid", d), 32'(out_valid), 32'd1);
            check($sformatf("bp_drain%0d_tag", d), 32'(out_tag), 32'(d));
            check($sformatf("bp_drain%0d_result", d), out_result, 32'((d + 1) * 2));
            step();
        end
        check("bp_empty", 32'(out_valid), 32'd0);
        check("bp_ready_back", 32'(in_ready), 32'd1);

        // Flush with s1, s2 and two FIFO entries occupied.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_op = 2'b00; in_rs1 = 32'(i + 5); in_rs2 = 32'd1;
            in_tag = TAG_W'(20 + i);
            step();
        end
        in_tag = 6'd30;
        flush  = 1'b1;
        #1;
        check("flush_ready_low", 32'(in_ready), 32'd0);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_ready_back", 32'(in_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("flush_quiet%0d", i), 32'(out_valid), 32'd0);
        end
        out_ready = 1'b1;
        issue_and_check("post_flush", 2'b00, 32'd3, 32'd3, 6'd7, 32'd9);

        // Asynchronous reset in the middle of a stream.
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_op = 2'(i); in_rs1 = 32'(100 + i); in_rs2 = 32'd3; in_tag = TAG_W'(40 + i);
            step();
        end
        check("pre_reset_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_valid", 32'(out_valid), 32'd0);
        check("async_reset_result", out_result, 32'd0);
        check("async_reset_tag", 32'(out_tag), 32'd0);
        in_valid = 1'b0;
        step();
        step();
        check("in_reset_valid", 32'(out_valid), 32'd0);
        rst_n = 1'b1;
        #1;
        check("post_reset_ready", 32'(in_ready), 32'd1);
        issue_and_check("post_reset_mulhu", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd33,
                        32'hFFFF_FFFE);

        // Randomized traffic, scored by the monitor.
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            in_op     = 2'($urandom_range(0, 3));
            in_rs1    = pick_operand();
            in_rs2    = pick_operand();
            in_tag    = TAG_W'($urandom);
            step();
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        drained   = 1'b0;
        for (int c = 0; c < 20 && !drained; c++) begin
            step();
            if (sb.size() == 0 && !out_valid) drained = 1'b1;
        end
        check("final_drain", 32'(drained), 32'd1);

`ifdef MUL_PERF_CNT_EN
        check("perf_ops", perf_ops, 32'(accepts));
        check("perf_stall", perf_stall, 32'(stalls));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
